// File: rtl/march_multi_patgen_if.sv
`default_nettype none
// ============================================================================
// Module   : march_multi_patgen_if
// Purpose  : Bus bundle between a BIST controller (master) and the March
//            pattern generator (slave).
// Signals  : start, alg_sel, bg_sel, en      -- run control (master -> slave)
//            addr, we, re, data, check, wmask -- one memory op per cycle
//            busy, done                       -- run status (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface march_multi_patgen_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  start;
    logic                  alg_sel;
    logic [1:0]            bg_sel;
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] check;
    logic [MASK_WIDTH-1:0] wmask;
    logic                  busy;
    logic                  done;

    modport master (
        output start, alg_sel, bg_sel, en,
        input  addr, we, re, data, check, wmask, busy, done
    );

    modport slave (
        input  start, alg_sel, bg_sel, en,
        output addr, we, re, data, check, wmask, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/march_multi_patgen.sv
`default_nettype none
// ============================================================================
// Module   : march_multi_patgen
// Purpose  : March C- (10N) / enhanced March C- (18N) op sequencer for SRAM
//            BIST over a column-muxed array with selectable data background.
//            addr = {row, col}; rows iterate fastest inside each column.
// Ports    : clk   -- clock, all state on posedge
//            rstb  -- synchronous active-low reset
//            bus   -- march_multi_patgen_if.slave (control, op, status)
// Option   : MARCH_MULTI_PATGEN_MASK_WALK_EN -- adds a write-mask walking
//            element MW between M4 and M5 (M5 then expects logical 1).
// Revision : 1.0  initial release
// ============================================================================
module march_multi_patgen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4,
    parameter int MAX_ADDR   = 255,
    parameter int MUX_RATIO  = 4
) (
    input  wire                 clk,
    input  wire                 rstb,
    march_multi_patgen_if.slave bus
);

    localparam int C_MUX_BITS = $clog2(MUX_RATIO);
    localparam int C_ROW_BITS = ADDR_WIDTH - C_MUX_BITS;
    localparam int C_NROWS    = (MAX_ADDR + 1) / MUX_RATIO;
    // Op index must cover 4 ops (enhanced) and 2*MASK_WIDTH ops (mask walk).
    localparam int C_OP_BITS  = $clog2(2 * MASK_WIDTH + 4);

    localparam logic [C_ROW_BITS-1:0] C_LAST_ROW = C_ROW_BITS'(C_NROWS - 1);
    localparam logic [C_MUX_BITS-1:0] C_LAST_COL = C_MUX_BITS'(MUX_RATIO - 1);

    // Checkerboard base word: bit i equals i[0] (…1010).
    function automatic logic [DATA_WIDTH-1:0] f_checker();
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p[i] = i[0];
        end
        return p;
    endfunction
    localparam logic [DATA_WIDTH-1:0] C_CHECKER = f_checker();

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_M0   = 4'd1,
        S_M1   = 4'd2,
        S_M2   = 4'd3,
        S_M3   = 4'd4,
        S_M4   = 4'd5,
        S_M5   = 4'd6,
        S_MW   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t                  state_q, state_d;
    logic [C_ROW_BITS-1:0]   row_q,   row_d;
    logic [C_MUX_BITS-1:0]   col_q,   col_d;
    logic [C_OP_BITS-1:0]    op_q,    op_d;
    logic                    alg_q,   alg_d;
    logic [1:0]              bg_q,    bg_d;

    // Per-element descriptors of the current state.
    logic [C_OP_BITS-1:0]    w_nops;
    logic                    w_down;
    state_t                  w_next;
    logic                    w_last_op;
    logic                    w_last_addr;
    logic                    w_active;

    // Op decode.
    logic                    w_write;
    logic                    w_read;
    logic                    w_val;
    logic                    w_mw;
    logic [DATA_WIDTH-1:0]   w_bg;
    logic [DATA_WIDTH-1:0]   w_phys;
    logic [DATA_WIDTH-1:0]   w_check;
    logic [MASK_WIDTH-1:0]   w_wmask;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            op_q    <= '0;
            alg_q   <= 1'b0;
            bg_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            op_q    <= op_d;
            alg_q   <= alg_d;
            bg_q    <= bg_d;
        end
    end

    // ------------------------------------------------------------------
    // Element descriptor: op count, direction, successor
    // ------------------------------------------------------------------
    always_comb begin
        w_nops = C_OP_BITS'(1);
        w_down = 1'b0;
        w_next = S_DONE;
        case (state_q)
            S_M0: w_next = S_M1;
            S_M1: begin
                w_nops = alg_q ? C_OP_BITS'(4) : C_OP_BITS'(2);
                w_next = S_M2;
            end
            S_M2: begin
                w_nops = alg_q ? C_OP_BITS'(4) : C_OP_BITS'(2);
                w_next = S_M3;
            end
            S_M3: begin
                w_nops = alg_q ? C_OP_BITS'(4) : C_OP_BITS'(2);
                w_down = 1'b1;
                w_next = S_M4;
            end
            S_M4: begin
                w_nops = alg_q ? C_OP_BITS'(4) : C_OP_BITS'(2);
                w_down = 1'b1;
`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
                w_next = S_MW;
`else
                w_next = S_M5;
`endif
            end
`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
            S_MW: begin
                w_nops = C_OP_BITS'(2 * MASK_WIDTH);
                w_next = S_M5;
            end
`endif
            S_M5: w_next = S_DONE;
            default: ;
        endcase
    end

    assign w_active    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign w_last_op   = (op_q == (w_nops - C_OP_BITS'(1)));
    assign w_last_addr = w_down ? ((row_q == '0) && (col_q == '0))
                                : ((row_q == C_LAST_ROW) && (col_q == C_LAST_COL));

    // ------------------------------------------------------------------
    // Next-state / counter sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        op_d    = op_q;
        alg_d   = alg_q;
        bg_d    = bg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    alg_d   = bus.alg_sel;
                    bg_d    = bus.bg_sel;
                    row_d   = '0;
                    col_d   = '0;
                    op_d    = '0;
                    state_d = S_M0;
                end
            end
            default: begin
                if (bus.en) begin
                    if (!w_last_op) begin
                        op_d = op_q + C_OP_BITS'(1);
                    end else begin
                        op_d = '0;
                        if (!w_last_addr) begin
                            if (w_down) begin
                                if (row_q == '0) begin
                                    row_d = C_LAST_ROW;
                                    col_d = col_q - C_MUX_BITS'(1);
                                end else begin
                                    row_d = row_q - C_ROW_BITS'(1);
                                end
                            end else begin
                                if (row_q == C_LAST_ROW) begin
                                    row_d = '0;
                                    col_d = col_q + C_MUX_BITS'(1);
                                end else begin
                                    row_d = row_q + C_ROW_BITS'(1);
                                end
                            end
                        end else begin
                            // Next element reloads its own first address.
                            state_d = w_next;
                            if ((w_next == S_M3) || (w_next == S_M4)) begin
                                row_d = C_LAST_ROW;
                                col_d = C_LAST_COL;
                            end else begin
                                row_d = '0;
                                col_d = '0;
                            end
                        end
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Op decode. Elements M1/M3 read 0 first then 1 (r0,w1,r1,w1);
    // M2/M4 mirror that (r1,w0,r0,w0). Writes sit on odd op indices.
    // ------------------------------------------------------------------
    always_comb begin
        w_write = 1'b0;
        w_read  = 1'b0;
        w_val   = 1'b0;
        w_mw    = 1'b0;
        case (state_q)
            S_M0: w_write = 1'b1;
            S_M1, S_M3: begin
                w_write = op_q[0];
                w_read  = ~op_q[0];
                w_val   = (op_q != '0);
            end
            S_M2, S_M4: begin
                w_write = op_q[0];
                w_read  = ~op_q[0];
                w_val   = (op_q == '0);
            end
`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
            S_MW: begin
                w_mw    = 1'b1;
                w_write = ~op_q[0];
                w_read  = op_q[0];
                w_val   = 1'b1;
            end
            S_M5: begin
                w_read  = 1'b1;
                w_val   = 1'b1;
            end
`else
            S_M5: w_read = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (bg_q)
            2'd1:    w_bg = C_CHECKER ^ {DATA_WIDTH{row_q[0] ^ col_q[0]}};
            2'd2:    w_bg = {DATA_WIDTH{row_q[0]}};
            default: w_bg = '0;
        endcase
    end

    assign w_phys = w_bg ^ {DATA_WIDTH{w_val}};

`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
    localparam int C_LANE_W = DATA_WIDTH / MASK_WIDTH;

    logic [C_OP_BITS-1:0]  w_k;
    logic [DATA_WIDTH-1:0] w_mw_check;

    // Op pair k: write lane k only, then read back. Lanes 0..k now hold 1.
    assign w_k = op_q >> 1;

    always_comb begin
        w_mw_check = w_bg;
        for (int l = 0; l < MASK_WIDTH; l++) begin
            if (C_OP_BITS'(l) <= w_k) begin
                w_mw_check[l*C_LANE_W +: C_LANE_W] = ~w_bg[l*C_LANE_W +: C_LANE_W];
            end
        end
    end

    assign w_check = w_mw ? w_mw_check : w_phys;
    assign w_wmask = (w_mw && w_write) ? (MASK_WIDTH'(1) << w_k) : '1;
`else
    assign w_check = w_phys;
    assign w_wmask = (w_mw) ? '0 : '1;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.addr  = w_active ? {row_q, col_q} : '0;
    assign bus.we    = w_write;
    assign bus.re    = w_read;
    assign bus.data  = w_write ? w_phys  : '0;
    assign bus.check = w_read  ? w_check : '0;
    assign bus.wmask = w_wmask;
    assign bus.busy  = w_active;
    assign bus.done  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_march_multi_patgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_march_multi_patgen
// Purpose  : Scoreboard bench for march_multi_patgen (MAX_ADDR=15, MUX=4).
//            The driver pushes the expected op stream of each run into a
//            queue; an independent monitor pops and compares per executed op.
// Revision : 1.0  initial release
// ============================================================================
module tb_march_multi_patgen;
    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int MW   = 4;
    localparam int MAXA = 15;
    localparam int MUX  = 4;
`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
    localparam int EXTRA = 2 * MW * (MAXA + 1);
`else
    localparam int EXTRA = 0;
`endif

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    march_multi_patgen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    march_multi_patgen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
        .MAX_ADDR(MAXA), .MUX_RATIO(MUX)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic          re;
        logic [DW-1:0] data;
        logic [DW-1:0] check;
        logic [MW-1:0] wmask;
    } op_t;

    op_t exp_q[$];
    op_t log_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Background word for an address: row = a/4, col = a%4.
    function automatic logic [DW-1:0] bgpat(input logic [1:0] bg, input int a);
        logic r0, c0;
        r0 = ((a >> 2) & 1) != 0;
        c0 = (a & 1) != 0;
        case (bg)
            2'd1:    return 32'hAAAA_AAAA ^ {DW{r0 ^ c0}};
            2'd2:    return {DW{r0}};
            default: return '0;
        endcase
    endfunction

    function automatic int addr_at(input bit down, input int i);
        int c, r;
        c = down ? (MUX - 1 - i / 4) : (i / 4);
        r = down ? (3 - i % 4) : (i % 4);
        return r * MUX + c;
    endfunction

    // codes: 2 bits per op, [1]=write, [0]=logical value; op j at [2j+:2].
    task automatic push_elem(input bit down, input int n, input logic [7:0] codes, input logic [1:0] bg);
        op_t o;
        int a;
        logic [1:0] cd;
        logic [DW-1:0] ph;
        for (int i = 0; i <= MAXA; i++) begin
            a = addr_at(down, i);
            for (int j = 0; j < n; j++) begin
                cd      = codes[2*j +: 2];
                ph      = bgpat(bg, a) ^ {DW{cd[0]}};
                o.addr  = AW'(a);
                o.we    = cd[1];
                o.re    = ~cd[1];
                o.data  = ph;
                o.check = ph;
                o.wmask = '1;
                exp_q.push_back(o);
            end
        end
    endtask

    task automatic push_run(input bit alg, input logic [1:0] bg);
        int n;
        n = alg ? 4 : 2;
        push_elem(1'b0, 1, 8'b10, bg);                       // M0 w0
        push_elem(1'b0, n, alg ? 8'hDC : 8'h0C, bg);         // M1
        push_elem(1'b0, n, alg ? 8'h89 : 8'h09, bg);         // M2
        push_elem(1'b1, n, alg ? 8'hDC : 8'h0C, bg);         // M3
        push_elem(1'b1, n, alg ? 8'h89 : 8'h09, bg);         // M4
`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
        begin
            op_t o;
            logic [DW-1:0] b;
            for (int i = 0; i <= MAXA; i++) begin
                b = bgpat(bg, i / 4 + (i % 4) * MUX);
                for (int k = 0; k < MW; k++) begin
                    o.addr  = AW'(i / 4 + (i % 4) * MUX);
                    o.we    = 1'b1;
                    o.re    = 1'b0;
                    o.data  = ~b;
                    o.check = '0;
                    o.wmask = MW'(1 << k);
                    exp_q.push_back(o);
                    o.we    = 1'b0;
                    o.re    = 1'b1;
                    o.wmask = '1;
                    for (int l = 0; l < MW; l++)
                        o.check[l*8 +: 8] = (l <= k) ? ~b[l*8 +: 8] : b[l*8 +: 8];
                    exp_q.push_back(o);
                end
            end
        end
        push_elem(1'b0, 1, 8'b01, bg);                       // M5 r1
`else
        push_elem(1'b0, 1, 8'b00, bg);                       // M5 r0
`endif
    endtask

    // Monitor: compares every busy cycle against the queue head; pops on en.
    initial begin
        op_t e, o;
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL extra_op: got addr %0h we %0b re %0b, required no op", bus.addr, bus.we, bus.re);
                end else begin
                    e = exp_q[0];
                    chk("op_addr", 64'(bus.addr), 64'(e.addr));
                    chk("op_we", 64'(bus.we), 64'(e.we));
                    chk("op_re", 64'(bus.re), 64'(e.re));
                    if (e.we) begin
                        chk("op_data", 64'(bus.data), 64'(e.data));
                        chk("op_wmask", 64'(bus.wmask), 64'(e.wmask));
                    end else begin
                        chk("op_check", 64'(bus.check), 64'(e.check));
                    end
                    if (bus.en) begin
                        void'(exp_q.pop_front());
                        o = '{bus.addr, bus.we, bus.re, bus.data, bus.check, bus.wmask};
                        log_q.push_back(o);
                    end
                end
            end
        end
    end

    task automatic chk_quiet(input string tag, input logic exp_done);
        chk({tag, "_busy"},  64'(bus.busy),  64'd0);
        chk({tag, "_done"},  64'(bus.done),  64'(exp_done));
        chk({tag, "_we"},    64'(bus.we),    64'd0);
        chk({tag, "_re"},    64'(bus.re),    64'd0);
        chk({tag, "_addr"},  64'(bus.addr),  64'd0);
        chk({tag, "_wmask"}, 64'(bus.wmask), 64'hF);
        chk({tag, "_data"},  64'(bus.data),  64'd0);
        chk({tag, "_check"}, 64'(bus.check), 64'd0);
    endtask

    // Starts a run and drives en until done, or until abort_at ops (then rstb=0).
    task automatic run(input bit alg, input logic [1:0] bg, input bit rnd,
                       input int abort_at, output int nops);
        int cyc;
        nops = 0;
        cyc  = 0;
        log_q.delete();
        push_run(alg, bg);
        bus.alg_sel = alg;
        bus.bg_sel  = bg;
        bus.start   = 1'b1;
        bus.en      = 1'b1;
        @(posedge clk); #1;
        bus.alg_sel = ~alg;
        bus.bg_sel  = ~bg;
        forever begin
            bus.en    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = (abort_at > 0 && nops >= 20 && nops < 23);
            if (bus.start) bus.alg_sel = 1'b1;
            @(negedge clk);
            if (!bus.busy) break;
            if (bus.en) nops++;
            if (abort_at > 0 && nops == abort_at) begin
                rstb = 1'b0;
                break;
            end
            cyc++;
            if (cyc > 3000) begin
                n_cmp++;
                n_mis++;
                $display("FAIL run_timeout: got %0d ops without done, required completion", nops);
                break;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int n;
        bus.start   = 1'b0;
        bus.alg_sel = 1'b0;
        bus.bg_sel  = 2'd0;
        bus.en      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset", 1'b0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // T1: March C-, solid background
        run(1'b0, 2'd0, 1'b0, 0, n);
        chk("t1_ops", 64'(n), 64'(160 + EXTRA));
        chk("t1_left", 64'(exp_q.size()), 64'd0);
        chk_quiet("t1_done", 1'b1);
        chk("t1_a0", 64'(log_q[0].addr), 64'd0);
        chk("t1_a1", 64'(log_q[1].addr), 64'd4);
        chk("t1_a2", 64'(log_q[2].addr), 64'd8);
        chk("t1_a3", 64'(log_q[3].addr), 64'd12);
        chk("t1_a4", 64'(log_q[4].addr), 64'd1);
        chk("t1_w0", 64'(log_q[4].we), 64'd1);
        chk("t1_m3_addr", 64'(log_q[80].addr), 64'd15);
        chk("t1_m3_re", 64'(log_q[80].re), 64'd1);
        repeat (3) @(negedge clk);
        chk("t1_done_held", 64'(bus.done), 64'd1);
        @(posedge clk); #1;

        // T2: enhanced March C-
        run(1'b1, 2'd0, 1'b0, 0, n);
        chk("t2_ops", 64'(n), 64'(288 + EXTRA));
        chk("t2_left", 64'(exp_q.size()), 64'd0);
        chk("t2_r0_re", 64'(log_q[16].re), 64'd1);
        chk("t2_r0_chk", 64'(log_q[16].check), 64'd0);
        chk("t2_w1_data", 64'(log_q[17].data), 64'hFFFF_FFFF);
        chk("t2_r1_chk", 64'(log_q[18].check), 64'hFFFF_FFFF);
        chk("t2_w1b_we", 64'(log_q[19].we), 64'd1);
        chk("t2_next_addr", 64'(log_q[20].addr), 64'd4);
        @(posedge clk); #1;

        // T3: checkerboard
        run(1'b0, 2'd1, 1'b0, 0, n);
        chk("t3_ops", 64'(n), 64'(160 + EXTRA));
        chk("t3_d_a0", 64'(log_q[0].data), 64'hAAAA_AAAA);
        chk("t3_d_a4", 64'(log_q[1].data), 64'h5555_5555);
        chk("t3_m1_a1", 64'(log_q[24].addr), 64'd1);
        chk("t3_m1_chk", 64'(log_q[24].check), 64'h5555_5555);
        @(posedge clk); #1;

        // Row stripe and bg=3 (solid) through the scoreboard only
        run(1'b1, 2'd2, 1'b0, 0, n);
        chk("stripe_ops", 64'(n), 64'(288 + EXTRA));
        @(posedge clk); #1;
        run(1'b0, 2'd3, 1'b0, 0, n);
        chk("bg3_ops", 64'(n), 64'(160 + EXTRA));
        @(posedge clk); #1;

        // T4: random en stalls
        run(1'b0, 2'd1, 1'b1, 0, n);
        chk("t4_ops", 64'(n), 64'(160 + EXTRA));
        chk("t4_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // T5: start pulse mid-run ignored, reset at op 50, full restart
        run(1'b0, 2'd0, 1'b0, 50, n);
        chk("t5_abort_ops", 64'(n), 64'd50);
        @(posedge clk);
        @(negedge clk);
        chk_quiet("t5_reset", 1'b0);
        exp_q.delete();
        rstb = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 2'd0, 1'b0, 0, n);
        chk("t5_rerun_ops", 64'(n), 64'(160 + EXTRA));
        chk("t5_left", 64'(exp_q.size()), 64'd0);

`ifdef MARCH_MULTI_PATGEN_MASK_WALK_EN
        // T6: mask walk at addr 0, k=1 (index 144 + 2)
        chk("t6_wmask", 64'(log_q[146].wmask), 64'h2);
        chk("t6_check", 64'(log_q[147].check), 64'h0000_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
